iexecute: RTL and testbench

Execute stage of the single-cycle core: consumes the decoded control fields and register operands from `iDecode`, performs the ALU operation, owns the NZCV flag register, resolves conditional branches into a redirect for `iFetch`, and runs an iterative 32-cycle multiplier that stalls the front end while busy. Results are registered and presented to writeback/memory one cycle later.

---
 rtl/scc_pkg.sv | 60 ++++++
 rtl/iexecute_if.sv | 37 +++
 rtl/iexecute_multiply.sv | 58 +++++
 rtl/iexecute.sv | 153 +++++++++++++++
 tb/tb_iexecute.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_pkg.sv
// Shared core definitions: ALU op codes, condition codes, NZCV bit positions,
// multiplier state encoding and the branch condition evaluator.
package scc_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_ORR = 3'd3,
        ALU_EOR = 3'd4,
        ALU_LSL = 3'd5,
        ALU_LSR = 3'd6,
        ALU_MOV = 3'd7
    } alu_fn_e;

    typedef enum logic [3:0] {
        CC_AL = 4'd0,  CC_EQ = 4'd1,  CC_NE = 4'd2,  CC_CS = 4'd3,
        CC_CC = 4'd4,  CC_MI = 4'd5,  CC_PL = 4'd6,  CC_VS = 4'd7,
        CC_VC = 4'd8,  CC_HI = 4'd9,  CC_LS = 4'd10, CC_GE = 4'd11,
        CC_LT = 4'd12, CC_GT = 4'd13, CC_LE = 4'd14, CC_NV = 4'd15
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cc)
            CC_AL:   pass = 1'b1;
            CC_EQ:   pass = z;
            CC_NE:   pass = ~z;
            CC_CS:   pass = c;
            CC_CC:   pass = ~c;
            CC_MI:   pass = n;
            CC_PL:   pass = ~n;
            CC_VS:   pass = v;
            CC_VC:   pass = ~v;
            CC_HI:   pass = c & ~z;
            CC_LS:   pass = ~c | z;
            CC_GE:   pass = (n == v);
            CC_LT:   pass = (n != v);
            CC_GT:   pass = ~z & (n == v);
            CC_LE:   pass = z | (n != v);
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/iexecute_if.sv
// Decode-to-execute bus: decoded control fields and operands in, registered
// result, flags, fetch redirect and front-end stall out.
interface iexecute_if #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
);
    logic              clk_en;
    logic              in_valid;
    logic [2:0]        aluFunction;
    logic              setFlags;
    logic              dataRegisterImm;
    logic              branch;
    logic [3:0]        branchInstruction;
    logic              mulStart;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic              resultValid;
    logic [3:0]        flags;
    logic              exeOverride;
    logic [DATA_W-1:0] exeData;
    logic              stall;

    modport master (
        output clk_en, in_valid, aluFunction, setFlags, dataRegisterImm, branch,
               branchInstruction, mulStart, opA, opB, imm, pc,
        input  result, resultValid, flags, exeOverride, exeData, stall
    );

    modport slave (
        input  clk_en, in_valid, aluFunction, setFlags, dataRegisterImm, branch,
               branchInstruction, mulStart, opA, opB, imm, pc,
        output result, resultValid, flags, exeOverride, exeData, stall
    );
endinterface

// File: rtl/iexecute_multiply.sv
// Iterative shift-add multiplier: one partial product per cycle, W cycles per
// operation; done is high during the final step with the low W product bits.
module iMultiply
    import scc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CW = $clog2(W);

    mul_state_e    state_q;
    logic [W-1:0]  a_q, b_q, acc_q, acc_step;
    logic [CW-1:0] cnt_q;

    assign acc_step = acc_q + (b_q[0] ? a_q : '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_step;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W-1)) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == ST_MUL);
    assign done    = busy && (cnt_q == CW'(W-1));
    assign product = acc_step;
endmodule

// File: rtl/iexecute.sv
// Execute stage: ALU, NZCV flag register, branch resolution to fetch and,
// when EXE_MUL_EN is defined, an iterative multiplier that stalls the front end.
module iexecute
    import scc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input logic       clk,
    input logic       rst,
    iexecute_if.slave bus
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] op_b, alu_res, br_target;
    logic [DATA_W:0]   add_w, sub_w;
    logic              alu_arith, alu_c, alu_v;
    logic              busy, accept, do_alu, do_branch;

    logic [DATA_W-1:0] result_q, result_d, exe_data_q, exe_data_d;
    logic              result_valid_q, result_valid_d;
    logic              exe_override_q, exe_override_d;
    logic [3:0]        flags_q, flags_d;

    // Nothing new is taken while a multiply occupies the stage.
    assign accept    = bus.in_valid & ~busy;
    assign do_branch = accept & bus.branch;
    assign do_alu    = accept & ~bus.branch & ~bus.mulStart;

    assign op_b      = bus.dataRegisterImm ? DATA_W'(bus.imm) : bus.opB;
    assign add_w     = {1'b0, bus.opA} + {1'b0, op_b};
    assign sub_w     = {1'b0, bus.opA} + {1'b0, ~op_b} + {{DATA_W{1'b0}}, 1'b1};
    assign br_target = bus.pc + {{(DATA_W-IMM_W-2){bus.imm[IMM_W-1]}}, bus.imm, 2'b00};

`ifdef EXE_MUL_EN
    logic              mul_start, mul_done, mul_sf_q, mul_sf_d;
    logic [DATA_W-1:0] mul_prod;

    assign mul_start = accept & bus.mulStart & ~bus.branch;

    iMultiply #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.clk_en),
        .start   (mul_start),
        .a       (bus.opA),
        .b       (op_b),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    assign bus.stall = mul_start | busy;
`else
    assign busy      = 1'b0;
    assign bus.stall = 1'b0;
`endif

    always_comb begin
        alu_res   = '0;
        alu_arith = 1'b0;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        case (bus.aluFunction)
            ALU_ADD: begin
                alu_res   = add_w[DATA_W-1:0];
                alu_arith = 1'b1;
                alu_c     = add_w[DATA_W];
                alu_v     = (bus.opA[DATA_W-1] == op_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != bus.opA[DATA_W-1]);
            end
            ALU_SUB: begin
                // Carry out of A + ~B + 1 is the "no borrow" flag.
                alu_res   = sub_w[DATA_W-1:0];
                alu_arith = 1'b1;
                alu_c     = sub_w[DATA_W];
                alu_v     = (bus.opA[DATA_W-1] != op_b[DATA_W-1]) &&
                            (alu_res[DATA_W-1] != bus.opA[DATA_W-1]);
            end
            ALU_AND: alu_res = bus.opA & op_b;
            ALU_ORR: alu_res = bus.opA | op_b;
            ALU_EOR: alu_res = bus.opA ^ op_b;
            ALU_LSL: alu_res = bus.opA << op_b[SH_W-1:0];
            ALU_LSR: alu_res = bus.opA >> op_b[SH_W-1:0];
            ALU_MOV: alu_res = op_b;
        endcase
    end

    always_comb begin
        result_d       = result_q;
        result_valid_d = 1'b0;
        exe_override_d = 1'b0;
        exe_data_d     = exe_data_q;
        flags_d        = flags_q;
`ifdef EXE_MUL_EN
        mul_sf_d       = mul_start ? bus.setFlags : mul_sf_q;
`endif
        if (do_alu) begin
            result_d       = alu_res;
            result_valid_d = 1'b1;
            if (bus.setFlags) begin
                flags_d[FLAG_N] = alu_res[DATA_W-1];
                flags_d[FLAG_Z] = (alu_res == '0);
                if (alu_arith) begin
                    flags_d[FLAG_C] = alu_c;
                    flags_d[FLAG_V] = alu_v;
                end
            end
        end else if (do_branch && cond_pass(bus.branchInstruction, flags_q)) begin
            exe_override_d = 1'b1;
            exe_data_d     = br_target;
        end
`ifdef EXE_MUL_EN
        if (mul_done) begin
            result_d       = mul_prod;
            result_valid_d = 1'b1;
            if (mul_sf_q) begin
                flags_d[FLAG_N] = mul_prod[DATA_W-1];
                flags_d[FLAG_Z] = (mul_prod == '0);
            end
        end
`endif
    end

    // clk_en low freezes everything, including the one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            exe_override_q <= 1'b0;
            exe_data_q     <= '0;
            flags_q        <= '0;
`ifdef EXE_MUL_EN
            mul_sf_q       <= 1'b0;
`endif
        end else if (bus.clk_en) begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            exe_override_q <= exe_override_d;
            exe_data_q     <= exe_data_d;
            flags_q        <= flags_d;
`ifdef EXE_MUL_EN
            mul_sf_q       <= mul_sf_d;
`endif
        end
    end

    assign bus.result      = result_q;
    assign bus.resultValid = result_valid_q;
    assign bus.exeOverride = exe_override_q;
    assign bus.exeData     = exe_data_q;
    assign bus.flags       = flags_q;
endmodule

// File: tb/tb_iexecute.sv
// Randomised bench for iexecute against a plain-arithmetic reference model of
// the ALU, NZCV rules, branch conditions and multiplier latency.
module tb_iexecute;
    logic clk = 1'b0;
    logic rst = 1'b0;

    iexecute_if bus ();
    iexecute dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] mf    = 4'b0000;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid        = 1'b0;
        bus.branch          = 1'b0;
        bus.mulStart        = 1'b0;
        bus.setFlags        = 1'b0;
        bus.dataRegisterImm = 1'b0;
    endtask

    function automatic void ref_alu(input int fn, input logic [31:0] a, input logic [31:0] b,
                                    input logic sf, inout logic [3:0] f, output logic [31:0] r);
        longint          sa, sb, sr;
        longint unsigned ua, ub;
        logic            c, v, arith;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        c = 1'b0; v = 1'b0; arith = 1'b0; sr = 0;
        case (fn)
            0: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; sr = sa + sb; arith = 1'b1; end
            1: begin r = a - b; c = (a >= b); sr = sa - sb; arith = 1'b1; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << b[4:0];
            6: r = a >> b[4:0];
            default: r = b;
        endcase
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (sf) begin
            f[3] = r[31];
            f[2] = (r == 32'd0);
            if (arith) begin
                f[1] = c;
                f[0] = v;
            end
        end
    endfunction

    function automatic bit ref_cond(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return !c;
            5:  return n;
            6:  return !n;
            7:  return v;
            8:  return !v;
            9:  return c && !z;
            10: return !c || z;
            11: return n == v;
            12: return n != v;
            13: return !z && (n == v);
            14: return z || (n != v);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_alu(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] im, input logic use_imm, input logic sf);
        logic [31:0] r, bv;
        bv = use_imm ? {16'h0000, im} : b;
        ref_alu(int'(fn), a, bv, sf, mf, r);
        bus.in_valid = 1'b1; bus.branch = 1'b0; bus.mulStart = 1'b0;
        bus.aluFunction = fn; bus.opA = a; bus.opB = b; bus.imm = im;
        bus.dataRegisterImm = use_imm; bus.setFlags = sf;
        tick();
        idle();
        chk("alu_valid", 32'(bus.resultValid), 32'd1);
        chk("alu_result", bus.result, r);
        chk("alu_flags", 32'(bus.flags), 32'(mf));
    endtask

    task automatic run_br(input logic [3:0] cc, input logic [31:0] p, input logic [15:0] im,
                          input logic with_mul);
        bit          tk;
        int          off;
        logic [31:0] tgt;
        tk  = ref_cond(cc, mf);
        off = int'($signed(im)) * 4;
        tgt = p + 32'(off);
        bus.in_valid = 1'b1; bus.branch = 1'b1; bus.mulStart = with_mul;
        bus.branchInstruction = cc; bus.pc = p; bus.imm = im; bus.setFlags = 1'b1;
        bus.aluFunction = 3'($urandom_range(0, 7)); bus.opA = $urandom; bus.opB = $urandom;
        #1;
        chk("br_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        chk("br_taken", 32'(bus.exeOverride), 32'(tk));
        if (tk) chk("br_target", bus.exeData, tgt);
        chk("br_no_result", 32'(bus.resultValid), 32'd0);
        chk("br_flags", 32'(bus.flags), 32'(mf));
        tick();
        chk("br_one_pulse", 32'(bus.exeOverride), 32'd0);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic sf,
                           input int abort_k);
        longint unsigned ua, ub, p;
        ua = a; ub = b; p = ua * ub;
        bus.in_valid = 1'b1; bus.mulStart = 1'b1; bus.branch = 1'b0;
        bus.aluFunction = 3'd0; bus.dataRegisterImm = 1'b0;
        bus.opA = a; bus.opB = b; bus.setFlags = sf;
`ifdef EXE_MUL_EN
        #1;
        chk("mul_stall_accept", 32'(bus.stall), 32'd1);
        tick();
        // An ADD presented while stalled must not be executed.
        bus.mulStart = 1'b0; bus.opA = 32'h1111_0000; bus.opB = 32'h0000_2222; bus.setFlags = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            if (k == abort_k) begin
                idle();
                rst = 1'b0;
                #1;
                mf = 4'b0000;
                chk("abort_stall", 32'(bus.stall), 32'd0);
                chk("abort_valid", 32'(bus.resultValid), 32'd0);
                chk("abort_flags", 32'(bus.flags), 32'd0);
                chk("abort_result", bus.result, 32'd0);
                rst = 1'b1;
                tick();
                return;
            end
            chk("mul_stall", 32'(bus.stall), 32'd1);
            chk("mul_busy_valid", 32'(bus.resultValid), 32'd0);
            tick();
        end
        idle();
        if (sf) begin
            mf[3] = p[31];
            mf[2] = (p[31:0] == 32'd0);
        end
        chk("mul_stall_end", 32'(bus.stall), 32'd0);
        chk("mul_valid", 32'(bus.resultValid), 32'd1);
        chk("mul_result", bus.result, p[31:0]);
        chk("mul_flags", 32'(bus.flags), 32'(mf));
`else
        #1;
        chk("nomul_stall", 32'(bus.stall), 32'd0);
        tick();
        idle();
        chk("nomul_valid", 32'(bus.resultValid), 32'd0);
        chk("nomul_flags", 32'(bus.flags), 32'(mf));
        chk("nomul_abort_unused", 32'(abort_k >= 0), 32'd1);
`endif
    endtask

    initial begin
        bus.clk_en = 1'b1;
        bus.aluFunction = 3'd0; bus.branchInstruction = 4'd0;
        bus.opA = '0; bus.opB = '0; bus.imm = '0; bus.pc = '0;
        idle();
        tick();
        tick();
        chk("rst_result", bus.result, 32'd0);
        chk("rst_valid", 32'(bus.resultValid), 32'd0);
        chk("rst_flags", 32'(bus.flags), 32'd0);
        chk("rst_override", 32'(bus.exeOverride), 32'd0);
        chk("rst_exedata", bus.exeData, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        rst = 1'b1;
        tick();

        run_alu(3'd0, 32'h7FFF_FFFF, 32'd1, 16'h0, 1'b0, 1'b1);
        chk("add_ovf_flags", 32'(bus.flags), 32'b1001);

        run_alu(3'd1, 32'd5, 32'd5, 16'h0, 1'b0, 1'b1);
        run_br(4'd1, 32'h100, 16'hFFFE, 1'b0);
        chk("eq_target", bus.exeData, 32'h0000_00F8);
        run_br(4'd2, 32'h200, 16'h0004, 1'b0);
        run_br(4'd15, 32'h300, 16'h0004, 1'b0);
        run_br(4'd0, 32'h400, 16'h0010, 1'b1);

        run_alu(3'd1, 32'd5, 32'd5, 16'h0, 1'b0, 1'b1);
        run_alu(3'd5, 32'd1, 32'd0, 16'd31, 1'b1, 1'b1);
        chk("lsl_flags", 32'(bus.flags), 32'b1010);

        // Frozen stage: pulse and result hold, new instruction is not taken.
        run_alu(3'd0, 32'd3, 32'd4, 16'h0, 1'b0, 1'b0);
        bus.clk_en = 1'b0;
        bus.in_valid = 1'b1; bus.aluFunction = 3'd1; bus.opA = 32'd9; bus.opB = 32'd2; bus.setFlags = 1'b1;
        tick(); tick(); tick();
        chk("hold_valid", 32'(bus.resultValid), 32'd1);
        chk("hold_result", bus.result, 32'd7);
        chk("hold_flags", 32'(bus.flags), 32'(mf));
        idle();
        bus.clk_en = 1'b1;
        tick();
        chk("resume_valid", 32'(bus.resultValid), 32'd0);

        run_mul(32'h1234_5678, 32'h0000_0010, 1'b1, 0);
`ifdef EXE_MUL_EN
        run_mul(32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 10);
        run_mul(32'd3, 32'd7, 1'b1, 0);
        chk("mul_3x7", bus.result, 32'd21);
`endif

        for (int i = 0; i < 200; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 65)
                run_alu(3'($urandom_range(0, 7)), pick(), pick(), 16'($urandom),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (sel < 95)
                run_br(4'($urandom_range(0, 15)), $urandom, 16'($urandom), 1'($urandom_range(0, 1)));
            else
                run_mul(pick(), pick(), 1'($urandom_range(0, 1)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
